bin_frac_seq_mult_param: RTL and testbench

Parametrised sequential sign-magnitude fractional multiplier. It generalises the fixed 7-bit shift-add multiplier to N magnitude bits. It adds a busy flag, start lockout, negative-zero normalisation and a rounded single-width result alongside the full product. It sits in the datapath lab blocks as the shared fractional multiply unit, driven by a controller through a start/done handshake.

---
 rtl/bin_frac_seq_mult_param.sv | 116 +++++++++++
 tb/tb_bin_frac_seq_mult_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_frac_seq_mult_param.sv
// Sequential sign-magnitude fractional multiplier, N magnitude bits per operand.
// Produces the full 2N-bit product and a rounded N-bit result after N shift-add steps.
module bin_frac_seq_mult_param #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   a,
    input  logic [N:0]   b,
    output logic         busy,
    output logic         done,
    output logic [2*N:0] product,
    output logic [N:0]   product_rnd
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     ma_q, ma_d;
    logic [N-1:0]     mb_q, mb_d;
    logic             sgn_q, sgn_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [2*N:0]     prod_q, prod_d;
    logic [N:0]       rnd_q, rnd_d;

    logic [N:0]       sum;
    logic [N-1:0]     addend;
    logic [N-1:0]     mag_r;

    // Partial product enters at weight 2^N; the N right shifts bring it home.
    assign addend = mb_q[0] ? ma_q : '0;
    assign sum    = {1'b0, acc_q[2*N-1:N]} + {1'b0, addend};
    assign mag_r  = acc_q[2*N-1:N] + N'(acc_q[N-1]);

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ma_d    = a[N-1:0];
                    mb_d    = b[N-1:0];
                    sgn_d   = a[N] ^ b[N];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = {sum, acc_q[N-1:1]};
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A zero magnitude never carries a sign bit.
                prod_d  = {sgn_q & (|acc_q), acc_q};
                rnd_d   = {sgn_q & (|mag_r), mag_r};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            prod_q  <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
            rnd_q   <= rnd_d;
        end
    end

    // Busy covers the result cycle too, even though a new start is already accepted there.
    assign busy        = (state_q != IDLE) | done_q;
    assign done        = done_q;
    assign product     = prod_q;
    assign product_rnd = rnd_q;

endmodule

// File: tb/tb_bin_frac_seq_mult_param.sv
// Scoreboard bench: directed N=6 cases plus randomized back-to-back N=12 operations.
// Expected results come from integer multiply and round-half-up on magnitudes.
module tb_bin_frac_seq_mult_param;

    typedef struct {
        longint p;
        longint r;
        int     cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start6 = 1'b0;
    logic [6:0]  a6 = '0, b6 = '0;
    logic        busy6, done6;
    logic [12:0] prod6;
    logic [6:0]  rnd6;

    logic        start12 = 1'b0;
    logic [12:0] a12 = '0, b12 = '0;
    logic        busy12, done12;
    logic [24:0] prod12;
    logic [12:0] rnd12;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t q6[$];
    exp_t q12[$];

    bin_frac_seq_mult_param #(.N(6)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .a(a6), .b(b6),
        .busy(busy6), .done(done6), .product(prod6), .product_rnd(rnd6)
    );

    bin_frac_seq_mult_param #(.N(12)) u12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .a(a12), .b(b12),
        .busy(busy12), .done(done12), .product(prod12), .product_rnd(rnd12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(int n, longint a, longint b, int c);
        exp_t e;
        longint one = 1;
        longint ma, mb, m, r, s;
        ma = a & ((one << n) - 1);
        mb = b & ((one << n) - 1);
        s  = ((a >> n) ^ (b >> n)) & 1;
        m  = ma * mb;
        r  = (m + (one << (n - 1))) >> n;
        assert (r < (one << n));
        e.p   = (s != 0 && m != 0) ? (m | (one << (2 * n))) : m;
        e.r   = (s != 0 && r != 0) ? (r | (one << n)) : r;
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done6) begin
            if (q6.size() == 0) begin
                check("done6_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q6.pop_front();
                check("prod6", prod6, e.p);
                check("rnd6", rnd6, e.r);
                check("done6_cycle", cyc, e.cyc);
                check("busy6_at_done", busy6, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done12) begin
            if (q12.size() == 0) begin
                check("done12_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q12.pop_front();
                check("prod12", prod12, e.p);
                check("rnd12", rnd12, e.r);
                check("done12_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue6(logic [6:0] x, logic [6:0] y, bit accepted);
        @(negedge clk);
        a6 = x;
        b6 = y;
        start6 = 1'b1;
        if (accepted) q6.push_back(model(6, longint'(x), longint'(y), cyc + 8));
        @(negedge clk);
        start6 = 1'b0;
    endtask

    task automatic wait_idle6();
        int k = 0;
        while ((q6.size() != 0 || busy6) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle6_timeout", (k >= 100), 0);
    endtask

    task automatic start12_op();
        logic [12:0] x, y;
        x = 13'($urandom_range(0, 8191));
        y = 13'($urandom_range(0, 8191));
        if ($urandom_range(0, 15) == 0) x[11:0] = '0;
        if ($urandom_range(0, 15) == 0) y[11:0] = 12'hfff;
        a12 = x;
        b12 = y;
        start12 = 1'b1;
        q12.push_back(model(12, longint'(x), longint'(y), cyc + 14));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy6", busy6, 0);
        check("rst_done6", done6, 0);
        check("rst_prod6", prod6, 0);
        check("rst_rnd6", rnd6, 0);
        check("rst_busy12", busy12, 0);
        check("rst_prod12", prod12, 0);
        rst_n = 1'b1;

        issue6(7'b0000100, 7'b0000010, 1);
        check("busy6_after_start", busy6, 1);
        wait_idle6();
        check("busy6_idle", busy6, 0);
        repeat (3) @(negedge clk);
        check("prod6_hold", prod6, 13'h0008);
        check("rnd6_hold", rnd6, 7'h00);

        issue6(7'b1100000, 7'b0100000, 1);
        wait_idle6();
        issue6(7'h03, 7'h0B, 1);
        wait_idle6();
        issue6(7'h3F, 7'h7F, 1);
        wait_idle6();
        issue6(7'b1000000, 7'b0010101, 1);
        wait_idle6();
        issue6(7'h7F, 7'h7F, 1);
        wait_idle6();
        issue6(7'h60, 7'h41, 1);
        wait_idle6();

        issue6(7'h25, 7'h31, 1);
        @(negedge clk);
        issue6(7'h7F, 7'h7F, 0);
        wait_idle6();

        issue6(7'h2A, 7'h35, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        q6.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy6", busy6, 0);
        check("midrst_done6", done6, 0);
        check("midrst_prod6", prod6, 0);
        check("midrst_rnd6", rnd6, 0);
        repeat (12) @(negedge clk);
        issue6(7'h3A, 7'h2B, 1);
        wait_idle6();

        @(negedge clk);
        start12_op();
        for (int i = 1; i < 200; i++) begin
            int k;
            @(negedge clk);
            start12 = 1'b0;
            k = 0;
            while (!done12 && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("done12_timeout", (k >= 40), 0);
            if (k >= 40) break;
            start12_op();
        end
        @(negedge clk);
        start12 = 1'b0;
        begin
            int k = 0;
            while ((q12.size() != 0 || busy12) && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("idle12_timeout", (k >= 100), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
